adder_unit: RTL and testbench

- Registered unsigned adder: two WIDTH-bit operands in, one (WIDTH+1)-bit sum out, carry-out kept in the MSB, so the result never overflows.
- Pipelined by a configurable number of register stages, with valid qualification on input and output.
- Leaf arithmetic block used by MACE datapath accumulation logic.

---
 rtl/adder_unit.sv | 83 ++++++++
 tb/tb_adder_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_unit.sv
// Pipelined unsigned adder: sum = a + b + cin at WIDTH+1 bits, LATENCY register stages.
// Define ADDER_UNIT_BACKPRESSURE_EN to add out_ready/in_ready flow control.
module adder_unit #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_UNIT_BACKPRESSURE_EN
    input  logic             out_ready,
    output logic             in_ready,
`endif
    output logic             out_valid,
    output logic [WIDTH:0]   sum
);

    localparam int unsigned SW = WIDTH + 1;

    logic              out_ready_c;
    logic [SW-1:0]     add_c;
    logic [LATENCY-1:0] vld_c;
    logic [LATENCY-1:0] adv_c;
    logic [SW-1:0]     sum_c [LATENCY];

`ifdef ADDER_UNIT_BACKPRESSURE_EN
    assign out_ready_c = out_ready;
    assign in_ready    = adv_c[0];
`else
    assign out_ready_c = 1'b1;
`endif

    assign add_c = SW'(a) + SW'(b) + SW'(cin);

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        logic          vin_c;
        logic [SW-1:0] din_c;
        logic          v_q, v_d;
        logic [SW-1:0] s_q, s_d;

        if (g == 0) begin : g_first
            assign vin_c = in_valid;
            assign din_c = add_c;
        end else begin : g_rest
            assign vin_c = vld_c[g-1];
            assign din_c = sum_c[g-1];
        end

        // A stage may move when the output drains or any slot at or above it is empty.
        assign adv_c[g] = out_ready_c || !(&vld_c[LATENCY-1:g]);

        always_comb begin
            v_d = v_q;
            s_d = s_q;
            if (adv_c[g]) begin
                v_d = vin_c;
                if (vin_c) begin
                    s_d = din_c;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                s_q <= '0;
            end else begin
                v_q <= v_d;
                s_q <= s_d;
            end
        end

        assign vld_c[g] = v_q;
        assign sum_c[g] = s_q;
    end

    assign out_valid = vld_c[LATENCY-1];
    assign sum       = sum_c[LATENCY-1];

endmodule

// File: tb/tb_adder_unit.sv
// Self-checking bench for adder_unit: LATENCY=1 and LATENCY=3 instances share stimulus
// and are compared every cycle against a history-based reference model.
module tb_adder_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       ov1, ov3;
    logic [4:0] s1, s3;
`ifdef ADDER_UNIT_BACKPRESSURE_EN
    logic       out_ready;
    logic       ir1, ir3;
`endif

    int tests = 0;
    int fails = 0;

    // Every accepted-or-idle cycle since reset release: valid flag and true sum.
    logic       hist_v [$];
    logic [4:0] hist_s [$];

    adder_unit #(.WIDTH(4), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
`ifdef ADDER_UNIT_BACKPRESSURE_EN
        .out_ready(out_ready), .in_ready(ir1),
`endif
        .out_valid(ov1), .sum(s1)
    );

    adder_unit #(.WIDTH(4), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
`ifdef ADDER_UNIT_BACKPRESSURE_EN
        .out_ready(out_ready), .in_ready(ir3),
`endif
        .out_valid(ov3), .sum(s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Output after L edges reflects the input sampled L-1 edges ago; sum is the latest valid result that has emerged.
    task automatic model(input int lat, output logic v, output logic [4:0] s);
        int  n;
        bit  found;
        n     = hist_v.size();
        v     = 1'b0;
        s     = 5'd0;
        found = 1'b0;
        if (n >= lat) v = hist_v[n-lat];
        for (int k = n - lat; k >= 0; k--) begin
            if (!found && hist_v[k]) begin
                s     = hist_s[k];
                found = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            hist_v.delete();
            hist_s.delete();
        end else begin
            hist_v.push_back(in_valid);
            hist_s.push_back(5'(a) + 5'(b) + 5'(cin));
        end
    end

    always @(negedge clk) begin
        logic       ev;
        logic [4:0] es;
        if (rst) begin
            ev = 1'b0;
            es = 5'd0;
            chk("model_l1_valid", 32'(ov1), 32'(ev));
            chk("model_l1_sum",   32'(s1),  32'(es));
            chk("model_l3_valid", 32'(ov3), 32'(ev));
            chk("model_l3_sum",   32'(s3),  32'(es));
        end else begin
            model(1, ev, es);
            chk("model_l1_valid", 32'(ov1), 32'(ev));
            chk("model_l1_sum",   32'(s1),  32'(es));
            model(3, ev, es);
            chk("model_l3_valid", 32'(ov3), 32'(ev));
            chk("model_l3_sum",   32'(s3),  32'(es));
        end
`ifdef ADDER_UNIT_BACKPRESSURE_EN
        if (!rst) begin
            chk("in_ready_l1", 32'(ir1), 32'd1);
            chk("in_ready_l3", 32'(ir3), 32'd1);
        end
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic cv);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = cv;
    endtask

    task automatic idle();
        drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    typedef struct { logic [3:0] a; logic [3:0] b; logic c; logic [4:0] s; } vec_t;
    vec_t vecs [6];

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
`ifdef ADDER_UNIT_BACKPRESSURE_EN
        out_ready = 1'b1;
`endif
        vecs[0] = '{4'd0,  4'd0,  1'b0, 5'd0};
        vecs[1] = '{4'd3,  4'd4,  1'b0, 5'd7};
        vecs[2] = '{4'd7,  4'd8,  1'b0, 5'd15};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 5'd30};
        vecs[4] = '{4'd15, 4'd15, 1'b1, 5'd31};
        vecs[5] = '{4'd0,  4'd0,  1'b1, 5'd1};

        repeat (3) tick();
        chk("reset_l1_valid", 32'(ov1), 32'd0);
        chk("reset_l1_sum",   32'(s1),  32'd0);
        chk("reset_l3_valid", 32'(ov3), 32'd0);
        chk("reset_l3_sum",   32'(s3),  32'd0);
        rst = 1'b0;
        idle();
        repeat (2) tick();
        chk("post_reset_l3_quiet", 32'(ov3), 32'd0);

        // Directed vectors back to back, LATENCY=1 result one edge after capture
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].c);
            tick();
            chk("vec_l1_valid", 32'(ov1), 32'd1);
            chk("vec_l1_sum",   32'(s1),  32'(vecs[i].s));
        end
        idle();
        repeat (4) tick();
        chk("vec_l3_held_sum", 32'(s3), 32'd1);

        // Streaming: 8 consecutive captures, LATENCY=3 valid from the third edge
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            tick();
            chk("stream_l3_valid", 32'(ov3), (i >= 2) ? 32'd1 : 32'd0);
        end
        idle();
        tick();
        chk("stream_l3_tail1", 32'(ov3), 32'd1);
        tick();
        chk("stream_l3_tail2", 32'(ov3), 32'd1);
        tick();
        chk("stream_l3_done", 32'(ov3), 32'd0);

        // Gaps: 1,0,1,0 twice
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else
                idle();
            tick();
            chk("gap_l1_valid", 32'(ov1), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        idle();
        repeat (4) tick();

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1)
                drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else
                idle();
            tick();
        end

        // Asynchronous reset with results in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd9, 4'd9, 1'b1);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_l1_valid", 32'(ov1), 32'd0);
        chk("async_rst_l1_sum",   32'(s1),  32'd0);
        chk("async_rst_l3_valid", 32'(ov3), 32'd0);
        chk("async_rst_l3_sum",   32'(s3),  32'd0);
        idle();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_l3_quiet", 32'(ov3), 32'd0);
            chk("post_rst_l1_quiet", 32'(ov1), 32'd0);
        end
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
